// File: rtl/pack_indication_pkg.sv
// Shared layout of the PackIndication heard frame, imported by both the
// method-to-pipe packer and the pipe-to-method deserializer.
package pack_indication_pkg;

    localparam int BEATS   = 4;
    localparam int BEAT_W  = 32;
    localparam int FRAME_W = BEATS * BEAT_W;

    localparam logic [15:0] METHOD_ID  = 16'd5;
    localparam logic [15:0] FRAME_BITS = 16'd96;

    localparam int LENGTH_LSB     = 0;
    localparam int SEQNO_LSB      = 48;
    localparam int READCOUNT_LSB  = 64;
    localparam int WRITECOUNT_LSB = 72;
    localparam int V_LSB          = 80;
    localparam int METHOD_LSB     = 96;

    typedef struct packed {
        logic [15:0] rsvd_top;
        logic [15:0] method_id;
        logic [7:0]  rsvd_mid;
        logic [7:0]  v;
        logic [7:0]  write_count;
        logic [7:0]  read_count;
        logic [15:0] seqno;
        logic [31:0] rsvd_low;
        logic [15:0] length;
    } heard_frame_t;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    // Builds a complete heard frame; used by the packer so both ends agree.
    function automatic logic [FRAME_W-1:0] pack_heard(
        input logic [7:0]  v,
        input logic [7:0]  write_count,
        input logic [7:0]  read_count,
        input logic [15:0] seqno
    );
        logic [FRAME_W-1:0] f;
        f = '0;
        f[METHOD_LSB +: 16]    = METHOD_ID;
        f[V_LSB +: 8]          = v;
        f[WRITECOUNT_LSB +: 8] = write_count;
        f[READCOUNT_LSB +: 8]  = read_count;
        f[SEQNO_LSB +: 16]     = seqno;
        f[LENGTH_LSB +: 16]    = FRAME_BITS;
        return f;
    endfunction

endpackage

// File: rtl/p2m_pack_indication_beat_assembler.sv
// Beat assembler: counts inbound pipe beats into frame slots and presents the
// full frame, including the final beat, on the cycle that beat transfers.
module p2m_pack_indication_beat_assembler #(
    parameter int BEATS  = pack_indication_pkg::BEATS,
    parameter int BEAT_W = pack_indication_pkg::BEAT_W
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    beat_fire_i,
    input  logic [BEAT_W-1:0]       beat_i,
    output logic [BEATS*BEAT_W-1:0] frame_o,
    output logic                    frame_done_o
);

    localparam int               IDX_W    = $clog2(BEATS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    logic [IDX_W-1:0]            idx_q;
    logic [IDX_W-1:0]            idx_d;
    logic [(BEATS-1)*BEAT_W-1:0] asm_q;
    logic [(BEATS-1)*BEAT_W-1:0] asm_d;
    logic                        last_beat;

    assign last_beat = (idx_q == LAST_IDX);

    // The last beat is never stored; it is forwarded straight into frame_o.
    always_comb begin
        idx_d = idx_q;
        asm_d = asm_q;
        if (beat_fire_i) begin
            if (last_beat) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
                asm_d[int'(idx_q)*BEAT_W +: BEAT_W] = beat_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q <= '0;
            asm_q <= '0;
        end else begin
            idx_q <= idx_d;
            asm_q <= asm_d;
        end
    end

    assign frame_o      = {beat_i, asm_q};
    assign frame_done_o = beat_fire_i && last_beat;

endmodule

// File: rtl/p2m_pack_indication.sv
// Pipe-to-method deserializer for PackIndication heard: rebuilds 4-beat frames,
// checks the header and presents the message with a ready/enable handshake.
module p2m_pack_indication #(
    parameter int          BEATS      = pack_indication_pkg::BEATS,
    parameter logic [15:0] METHOD_ID  = pack_indication_pkg::METHOD_ID,
    parameter logic [15:0] FRAME_BITS = pack_indication_pkg::FRAME_BITS
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        pipe_enq__ENA,
    input  logic [31:0] pipe_enq_v,
    output logic        pipe_enq__RDY,
    output logic        method_heard__ENA,
    output logic [7:0]  method_heard_v,
    output logic [7:0]  method_heard_writeCount,
    output logic [7:0]  method_heard_readCount,
    output logic [15:0] method_heard_seqno,
    input  logic        method_heard__RDY,
    output logic [7:0]  err_count
);

    import pack_indication_pkg::*;

    state_e                    state_q;
    state_e                    state_d;
    logic [7:0]                v_q;
    logic [7:0]                v_d;
    logic [7:0]                write_count_q;
    logic [7:0]                write_count_d;
    logic [7:0]                read_count_q;
    logic [7:0]                read_count_d;
    logic [15:0]               seqno_q;
    logic [15:0]               seqno_d;
    logic [7:0]                err_q;
    logic [7:0]                err_d;

    logic                      beat_fire;
    logic [BEATS*BEAT_W-1:0]   frame;
    logic                      frame_done;
    heard_frame_t              hdr;
    logic                      hdr_ok;
    logic                      unused_rsvd;

    assign beat_fire = pipe_enq__ENA && (state_q == COLLECT);

    p2m_pack_indication_beat_assembler #(
        .BEATS  (BEATS),
        .BEAT_W (BEAT_W)
    ) u_assembler (
        .clk_i        (CLK),
        .rst_i        (RST),
        .beat_fire_i  (beat_fire),
        .beat_i       (pipe_enq_v),
        .frame_o      (frame),
        .frame_done_o (frame_done)
    );

    assign hdr         = frame;
    assign hdr_ok      = (hdr.method_id == METHOD_ID) && (hdr.length == FRAME_BITS);
    // Reserved-zero fields are intentionally not checked.
    assign unused_rsvd = ^{hdr.rsvd_top, hdr.rsvd_mid, hdr.rsvd_low};

    always_comb begin
        state_d       = state_q;
        v_d           = v_q;
        write_count_d = write_count_q;
        read_count_d  = read_count_q;
        seqno_d       = seqno_q;
        err_d         = err_q;
        case (state_q)
            COLLECT: begin
                if (frame_done) begin
                    if (hdr_ok) begin
                        v_d           = hdr.v;
                        write_count_d = hdr.write_count;
                        read_count_d  = hdr.read_count;
                        seqno_d       = hdr.seqno;
                        state_d       = HOLD;
                    end else if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                end
            end
            HOLD: begin
                if (method_heard__RDY) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= COLLECT;
            v_q           <= '0;
            write_count_q <= '0;
            read_count_q  <= '0;
            seqno_q       <= '0;
            err_q         <= '0;
        end else begin
            state_q       <= state_d;
            v_q           <= v_d;
            write_count_q <= write_count_d;
            read_count_q  <= read_count_d;
            seqno_q       <= seqno_d;
            err_q         <= err_d;
        end
    end

    assign pipe_enq__RDY           = (state_q == COLLECT);
    assign method_heard__ENA       = (state_q == HOLD);
    assign method_heard_v          = v_q;
    assign method_heard_writeCount = write_count_q;
    assign method_heard_readCount  = read_count_q;
    assign method_heard_seqno      = seqno_q;
    assign err_count               = err_q;

endmodule

// File: tb/tb_p2m_pack_indication.sv
// Scoreboard bench for p2m_pack_indication: directed frames push expected
// heard messages; a negedge monitor compares whatever the DUT presents.
module tb_p2m_pack_indication;

    logic        CLK = 1'b0;
    logic        RST;
    logic        pipe_enq__ENA;
    logic [31:0] pipe_enq_v;
    logic        pipe_enq__RDY;
    logic        method_heard__ENA;
    logic [7:0]  method_heard_v;
    logic [7:0]  method_heard_writeCount;
    logic [7:0]  method_heard_readCount;
    logic [15:0] method_heard_seqno;
    logic        method_heard__RDY;
    logic [7:0]  err_count;

    typedef struct packed {
        logic [7:0]  v;
        logic [7:0]  wc;
        logic [7:0]  rc;
        logic [15:0] seq;
    } msg_t;

    msg_t expQ[$];
    int   checks   = 0;
    int   failures = 0;

    // Frames listed beat3..beat0; field values worked out by hand from the layout.
    localparam logic [127:0] GOOD_A  = {32'h00000005, 32'h00AB1103, 32'h12340000, 32'h00000060};
    localparam logic [127:0] GOOD_B  = {32'h00000005, 32'h007F80C4, 32'hBEEF0000, 32'h00000060};
    localparam logic [127:0] GOOD_R  = {32'hFFFF0005, 32'hFF010203, 32'h0001FFFF, 32'hFFFF0060};
    localparam logic [127:0] BAD_LEN = {32'h00000005, 32'h00AB1103, 32'h12340000, 32'h00000050};
    localparam logic [127:0] BAD_MID = {32'h00000006, 32'h00AB1103, 32'h12340000, 32'h00000060};

    p2m_pack_indication dut (
        .CLK                     (CLK),
        .RST                     (RST),
        .pipe_enq__ENA           (pipe_enq__ENA),
        .pipe_enq_v              (pipe_enq_v),
        .pipe_enq__RDY           (pipe_enq__RDY),
        .method_heard__ENA       (method_heard__ENA),
        .method_heard_v          (method_heard_v),
        .method_heard_writeCount (method_heard_writeCount),
        .method_heard_readCount  (method_heard_readCount),
        .method_heard_seqno      (method_heard_seqno),
        .method_heard__RDY       (method_heard__RDY),
        .err_count               (err_count)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic expectMsg(input logic [7:0] v, input logic [7:0] wc, input logic [7:0] rc,
                             input logic [15:0] seq);
        msg_t m;
        m.v   = v;
        m.wc  = wc;
        m.rc  = rc;
        m.seq = seq;
        expQ.push_back(m);
    endtask

    // Sends nBeats beats of f, with gap idle cycles between beats.
    task automatic applyStimulus(input logic [127:0] f, input int gap, input int nBeats);
        for (int i = 0; i < nBeats; i++) begin
            int budget = 0;
            pipe_enq__ENA = 1'b1;
            pipe_enq_v    = f[i*32 +: 32];
            while (pipe_enq__RDY !== 1'b1 && budget < 20) begin
                tick();
                budget++;
            end
            if (budget >= 20) begin
                checks++;
                failures++;
                $display("[TB] FAIL enq_rdy_timeout: got enq__RDY=%b expected 1 within 20 cycles", pipe_enq__RDY);
            end
            tick();
            pipe_enq__ENA = 1'b0;
            if (i != nBeats - 1) repeat (gap) tick();
        end
    endtask

    // Monitor: every presented message must match the scoreboard head.
    initial begin
        forever begin
            @(negedge CLK);
            if (method_heard__ENA === 1'b1) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_heard: got v=%0h wc=%0h rc=%0h seq=%0h expected no message",
                             method_heard_v, method_heard_writeCount, method_heard_readCount, method_heard_seqno);
                end else begin
                    checkOutput("heard_fields",
                                {24'h0, method_heard_v, method_heard_writeCount, method_heard_readCount, method_heard_seqno},
                                {24'h0, expQ[0]});
                    if (method_heard__RDY === 1'b1) void'(expQ.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST               = 1'b1;
        pipe_enq__ENA     = 1'b0;
        pipe_enq_v        = '0;
        method_heard__RDY = 1'b1;
        repeat (2) tick();
        RST = 1'b0;

        checkOutput("rst_enq_rdy", 64'(pipe_enq__RDY), 64'd1);
        checkOutput("rst_heard_ena", 64'(method_heard__ENA), 64'd0);
        checkOutput("rst_fields", {24'h0, method_heard_v, method_heard_writeCount,
                    method_heard_readCount, method_heard_seqno}, 64'd0);
        checkOutput("rst_err", 64'(err_count), 64'd0);

        $display("[TB] good frame, consumer ready");
        expectMsg(8'hAB, 8'h11, 8'h03, 16'h1234);
        applyStimulus(GOOD_A, 0, 4);
        checkOutput("lat_ena_n1", 64'(method_heard__ENA), 64'd1);
        checkOutput("lat_enq_rdy_low", 64'(pipe_enq__RDY), 64'd0);
        tick();
        checkOutput("lat_ena_drop", 64'(method_heard__ENA), 64'd0);
        checkOutput("lat_enq_rdy_back", 64'(pipe_enq__RDY), 64'd1);
        checkOutput("good_err", 64'(err_count), 64'd0);

        $display("[TB] consumer stalls five cycles, transport pushes during hold");
        method_heard__RDY = 1'b0;
        expectMsg(8'h7F, 8'h80, 8'hC4, 16'hBEEF);
        applyStimulus(GOOD_B, 0, 4);
        pipe_enq__ENA = 1'b1;
        pipe_enq_v    = 32'hDEADBEEF;
        for (int c = 0; c < 5; c++) begin
            checkOutput("hold_ena", 64'(method_heard__ENA), 64'd1);
            checkOutput("hold_enq_rdy", 64'(pipe_enq__RDY), 64'd0);
            tick();
        end
        method_heard__RDY = 1'b1;
        pipe_enq__ENA     = 1'b0;
        tick();
        checkOutput("hold_release", 64'(method_heard__ENA), 64'd0);
        checkOutput("hold_enq_rdy_back", 64'(pipe_enq__RDY), 64'd1);
        expectMsg(8'hAB, 8'h11, 8'h03, 16'h1234);
        applyStimulus(GOOD_A, 0, 4);
        tick();

        $display("[TB] bad headers, then reserved bits set on a good header");
        applyStimulus(BAD_LEN, 0, 4);
        checkOutput("badlen_no_ena", 64'(method_heard__ENA), 64'd0);
        checkOutput("badlen_err", 64'(err_count), 64'd1);
        applyStimulus(BAD_MID, 0, 4);
        checkOutput("badmid_no_ena", 64'(method_heard__ENA), 64'd0);
        checkOutput("badmid_err", 64'(err_count), 64'd2);
        expectMsg(8'h01, 8'h02, 8'h03, 16'h0001);
        applyStimulus(GOOD_R, 0, 4);
        checkOutput("rsvd_ena", 64'(method_heard__ENA), 64'd1);
        tick();
        checkOutput("rsvd_err", 64'(err_count), 64'd2);

        $display("[TB] error counter saturation");
        for (int k = 0; k < 252; k++) applyStimulus((k % 2 == 0) ? BAD_LEN : BAD_MID, 0, 4);
        checkOutput("sat_err_254", 64'(err_count), 64'd254);
        applyStimulus(BAD_LEN, 0, 4);
        checkOutput("sat_err_255", 64'(err_count), 64'd255);
        applyStimulus(BAD_MID, 0, 4);
        applyStimulus(BAD_LEN, 0, 4);
        checkOutput("sat_err_hold", 64'(err_count), 64'd255);

        $display("[TB] gaps between beats");
        expectMsg(8'hAB, 8'h11, 8'h03, 16'h1234);
        applyStimulus(GOOD_A, 2, 4);
        checkOutput("gap_ena", 64'(method_heard__ENA), 64'd1);
        tick();

        $display("[TB] reset after three beats");
        applyStimulus(GOOD_B, 0, 3);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checkOutput("midrst_err", 64'(err_count), 64'd0);
        checkOutput("midrst_enq_rdy", 64'(pipe_enq__RDY), 64'd1);
        expectMsg(8'hAB, 8'h11, 8'h03, 16'h1234);
        applyStimulus(GOOD_A, 0, 4);
        checkOutput("midrst_ena", 64'(method_heard__ENA), 64'd1);
        tick();

        $display("[TB] reset during hold");
        method_heard__RDY = 1'b0;
        expectMsg(8'h7F, 8'h80, 8'hC4, 16'hBEEF);
        applyStimulus(GOOD_B, 0, 4);
        checkOutput("holdrst_pre_ena", 64'(method_heard__ENA), 64'd1);
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        method_heard__RDY = 1'b1;
        expQ.delete();
        checkOutput("holdrst_ena", 64'(method_heard__ENA), 64'd0);
        checkOutput("holdrst_fields", {24'h0, method_heard_v, method_heard_writeCount,
                    method_heard_readCount, method_heard_seqno}, 64'd0);
        checkOutput("holdrst_err", 64'(err_count), 64'd0);
        checkOutput("holdrst_enq_rdy", 64'(pipe_enq__RDY), 64'd1);
        repeat (3) tick();

        checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
